// File: rtl/core_pkg.sv
// Shared core constants for the fetch slice.
package core_pkg;
   localparam int unsigned RESET_PC_DEFAULT = 0;
   localparam int unsigned INSTR_BYTES      = 4;
   localparam int unsigned INSTR_BITS       = 32;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction-memory request/response channel plus the fetch/decode handshake.
interface fetch_unit_if
   import core_pkg::*;
#(
   parameter int unsigned ADDRESS_BITS = 16
);
   logic                    imem_req_valid;
   logic                    imem_req_ready;
   logic [ADDRESS_BITS-1:0] imem_req_addr;
   logic                    imem_rsp_valid;
   logic [INSTR_BITS-1:0]   imem_rsp_data;
   logic                    next_PC_select;
   logic [ADDRESS_BITS-1:0] target_PC;
   logic                    dec_valid;
   logic                    dec_ready;
   logic [ADDRESS_BITS-1:0] PC;
   logic [INSTR_BITS-1:0]   instruction;

   modport master (
      output imem_req_valid, imem_req_addr, dec_valid, PC, instruction,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, next_PC_select, target_PC, dec_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, dec_valid, PC, instruction,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, next_PC_select, target_PC, dec_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head reads zero when empty.
module fetch_fifo
   import core_pkg::*;
#(
   parameter  int unsigned WIDTH = 16,
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage write, no reset needed on the data array.
   always_ff @(posedge clock) begin
      if (push && !reset && !flush) mem[wr_ptr] <= push_data;
   end

   assign head = (count == '0) ? '0 : mem[rd_ptr];

   // Occupancy sanity checks: never pop empty, never push into a full queue without a pop.
   always_ff @(posedge clock) begin
      if (!reset && !flush) begin
         assert (!(pop && count == '0));
         assert (!(push && !pop && count == CW'(DEPTH)));
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem reads, buffers
// responses and hands {PC, instruction} to decode; squashes wrong-path fetches on redirect.
module fetch_unit
   import core_pkg::*;
#(
   parameter int unsigned ADDRESS_BITS = 16,
   parameter int unsigned RESET_PC     = RESET_PC_DEFAULT,
   parameter int unsigned FIFO_DEPTH   = 2
) (
   input  logic         clock,
   input  logic         reset,
   fetch_unit_if.master bus
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned RW = ADDRESS_BITS + INSTR_BITS;
   localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

   logic [ADDRESS_BITS-1:0] fetch_pc;
   logic [CW-1:0]           in_flight;
   logic [CW-1:0]           drop_cnt;
   logic [CW-1:0]           pend_count;
   logic [CW-1:0]           buf_count;
   logic [ADDRESS_BITS-1:0] pend_head;
   logic [RW-1:0]           buf_head;
   logic                    req_fire;
   logic                    dec_fire;
   logic                    redirect;
   logic                    rsp_drop;
   logic [CW:0]             credit_used;

   assign dec_fire = bus.dec_valid & bus.dec_ready;
   assign redirect = dec_fire & bus.next_PC_select;
   assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
   assign rsp_drop = (drop_cnt != '0) | redirect;

   // The slot vacated by a same-cycle decode pop is reusable at once, which
   // keeps a latency-1 memory streaming one instruction per cycle.
   assign credit_used = {1'b0, in_flight} + {1'b0, buf_count} - {{CW{1'b0}}, dec_fire};

   assign bus.imem_req_valid = !reset && !redirect && (credit_used < DEPTH_LIM);
   assign bus.imem_req_addr  = fetch_pc;
   assign bus.dec_valid      = (buf_count != '0);
   assign bus.PC             = buf_head[RW-1 -: ADDRESS_BITS];
   assign bus.instruction    = buf_head[INSTR_BITS-1:0];

   fetch_fifo #(.WIDTH(ADDRESS_BITS), .DEPTH(FIFO_DEPTH)) u_pend_q (
      .clock     (clock),
      .reset     (reset),
      .push      (req_fire),
      .push_data (fetch_pc),
      .pop       (bus.imem_rsp_valid),
      .flush     (1'b0),
      .count     (pend_count),
      .head      (pend_head)
   );

   fetch_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_rsp_buf (
      .clock     (clock),
      .reset     (reset),
      .push      (bus.imem_rsp_valid & ~rsp_drop),
      .push_data ({pend_head, bus.imem_rsp_data}),
      .pop       (dec_fire & ~redirect),
      .flush     (redirect),
      .count     (buf_count),
      .head      (buf_head)
   );

   // PC, outstanding-request and wrong-path drop bookkeeping.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc  <= ADDRESS_BITS'(RESET_PC);
         in_flight <= '0;
         drop_cnt  <= '0;
      end else begin
         in_flight <= in_flight + CW'(req_fire) - CW'(bus.imem_rsp_valid);
         if (redirect) begin
            fetch_pc <= bus.target_PC & ~ADDRESS_BITS'(3);
            // Everything still outstanding is wrong-path; requests issued after an
            // earlier redirect are included, so this already covers accumulation.
            drop_cnt <= in_flight - CW'(bus.imem_rsp_valid);
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + ADDRESS_BITS'(INSTR_BYTES);
            if (bus.imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   // Counter consistency: no response without a request, drops bounded by outstanding work.
   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (!(bus.imem_rsp_valid && in_flight == '0));
         assert (drop_cnt <= in_flight);
         assert (pend_count == in_flight);
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirect, wrap, random scoreboard, mid-flight reset.
module tb_fetch_unit;
   import core_pkg::*;

   localparam int unsigned AB = 16;

   typedef struct {
      int unsigned   due;
      logic [AB-1:0] addr;
   } pend_t;

   logic        clock = 1'b0;
   logic        reset;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned mem_lat = 1;
   int unsigned mcyc = 0;
   int unsigned wcyc = 0;
   pend_t       mq[$];
   pend_t       wq[$];

   fetch_unit_if #(.ADDRESS_BITS(AB)) bus ();
   fetch_unit_if #(.ADDRESS_BITS(AB)) bus_w ();

   fetch_unit #(.ADDRESS_BITS(AB), .RESET_PC(0), .FIFO_DEPTH(2)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   fetch_unit #(.ADDRESS_BITS(AB), .RESET_PC(32'hFFF8), .FIFO_DEPTH(2)) u_wrap (
      .clock (clock),
      .reset (reset),
      .bus   (bus_w)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [AB-1:0] a);
      return {a ^ 16'hC35A, a};
   endfunction

   // Instruction memory for the main DUT: fixed latency mem_lat, in order, reset with the core.
   initial begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      forever begin
         @(negedge clock);
         if (reset) mq.delete();
         else if (bus.imem_req_valid && bus.imem_req_ready)
            mq.push_back('{due: mcyc + mem_lat, addr: bus.imem_req_addr});
         @(posedge clock);
         #1;
         mcyc++;
         if (mq.size() > 0 && mq[0].due == mcyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
         end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
         end
      end
   end

   // Latency-1 memory and always-ready decode for the wrap-around instance.
   initial begin
      bus_w.imem_rsp_valid = 1'b0;
      bus_w.imem_rsp_data  = '0;
      bus_w.imem_req_ready = 1'b1;
      bus_w.dec_ready      = 1'b1;
      bus_w.next_PC_select = 1'b0;
      bus_w.target_PC      = '0;
      forever begin
         @(negedge clock);
         if (reset) wq.delete();
         else if (bus_w.imem_req_valid && bus_w.imem_req_ready)
            wq.push_back('{due: wcyc + 1, addr: bus_w.imem_req_addr});
         @(posedge clock);
         #1;
         wcyc++;
         if (wq.size() > 0 && wq[0].due == wcyc) begin
            bus_w.imem_rsp_valid = 1'b1;
            bus_w.imem_rsp_data  = mem_word(wq[0].addr);
            void'(wq.pop_front());
         end else begin
            bus_w.imem_rsp_valid = 1'b0;
            bus_w.imem_rsp_data  = '0;
         end
      end
   end

   task automatic do_reset(input int unsigned lat, input logic drdy);
      @(posedge clock); #2;
      reset              = 1'b1;
      mem_lat            = lat;
      bus.imem_req_ready = 1'b1;
      bus.dec_ready      = drdy;
      bus.next_PC_select = 1'b0;
      bus.target_PC      = '0;
      @(posedge clock); #2;
      @(posedge clock); #2;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset              = 1'b1;
      bus.imem_req_ready = 1'b1;
      bus.dec_ready      = 1'b1;
      bus.next_PC_select = 1'b0;
      bus.target_PC      = '0;
      @(posedge clock); #2;
      @(posedge clock); #2;
      @(negedge clock);
      vectors++;
      if (bus.imem_req_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid);
      end
      vectors++;
      if (bus.dec_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_dec_valid: got %b expected 0", bus.dec_valid);
      end
      vectors++;
      if (bus.PC !== 16'h0000) begin
         miscompares++; $display("FAIL reset_pc: got %h expected 0000", bus.PC);
      end
      vectors++;
      if (bus.instruction !== 32'h0) begin
         miscompares++; $display("FAIL reset_instr: got %h expected 00000000", bus.instruction);
      end
   endtask

   task automatic test_stream();
      logic [AB-1:0] exp_pc;
      do_reset(1, 1'b1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         vectors++;
         if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 16'(4 * k)) begin
            miscompares++;
            $display("FAIL stream_req[%0d]: got v=%b a=%h expected v=1 a=%h", k, bus.imem_req_valid, bus.imem_req_addr, 16'(4 * k));
         end
         vectors++;
         if (bus.dec_valid !== (k >= 2)) begin
            miscompares++; $display("FAIL stream_dec_valid[%0d]: got %b expected %b", k, bus.dec_valid, (k >= 2));
         end
         if (k >= 2) begin
            exp_pc = 16'(4 * (k - 2));
            vectors++;
            if (bus.PC !== exp_pc || bus.instruction !== mem_word(exp_pc)) begin
               miscompares++;
               $display("FAIL stream_dec[%0d]: got pc=%h ins=%h expected pc=%h ins=%h", k, bus.PC, bus.instruction, exp_pc, mem_word(exp_pc));
            end
         end
         @(posedge clock); #2;
      end
   endtask

   task automatic test_backpressure();
      int unsigned fires = 0;
      int unsigned got = 0;
      do_reset(1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (bus.imem_req_valid && bus.imem_req_ready) fires++;
         if (k == 9) begin
            vectors++;
            if (bus.imem_req_valid !== 1'b0) begin
               miscompares++; $display("FAIL bp_req_stalled: got %b expected 0", bus.imem_req_valid);
            end
         end
         @(posedge clock); #2;
      end
      vectors++;
      if (fires != 2) begin
         miscompares++; $display("FAIL bp_issue_count: got %0d expected 2", fires);
      end
      bus.dec_ready = 1'b1;
      for (int c = 0; c < 30 && got < 6; c++) begin
         @(negedge clock);
         if (bus.dec_valid) begin
            vectors++;
            if (bus.PC !== 16'(4 * got) || bus.instruction !== mem_word(16'(4 * got))) begin
               miscompares++;
               $display("FAIL bp_release[%0d]: got pc=%h ins=%h expected pc=%h", got, bus.PC, bus.instruction, 16'(4 * got));
            end
            got++;
         end
         @(posedge clock); #2;
      end
      vectors++;
      if (got != 6) begin
         miscompares++; $display("FAIL bp_timeout: got %0d decodes expected 6", got);
      end
   endtask

   task automatic test_redirect();
      logic [AB-1:0] exp_seq [6];
      int unsigned   got = 0;
      logic          sel;
      logic          redirected = 1'b0;
      logic          req_seen = 1'b0;
      exp_seq = '{16'h0000, 16'h0004, 16'h0008, 16'h0040, 16'h0044, 16'h0048};
      do_reset(3, 1'b1);
      for (int c = 0; c < 80 && got < 6; c++) begin
         sel = !redirected && bus.dec_valid && bus.PC == 16'h0008;
         bus.next_PC_select = sel;
         bus.target_PC      = 16'h0041;
         @(negedge clock);
         if (bus.dec_valid && bus.dec_ready) begin
            vectors++;
            if (bus.PC !== exp_seq[got] || bus.instruction !== mem_word(exp_seq[got])) begin
               miscompares++;
               $display("FAIL redir_dec[%0d]: got pc=%h ins=%h expected pc=%h", got, bus.PC, bus.instruction, exp_seq[got]);
            end
            got++;
         end
         if (sel) begin
            redirected = 1'b1;
            vectors++;
            if (bus.imem_req_valid !== 1'b0) begin
               miscompares++; $display("FAIL redir_req_blocked: got %b expected 0", bus.imem_req_valid);
            end
         end else if (redirected && !req_seen && bus.imem_req_valid && bus.imem_req_ready) begin
            req_seen = 1'b1;
            vectors++;
            if (bus.imem_req_addr !== 16'h0040) begin
               miscompares++; $display("FAIL redir_first_req: got %h expected 0040", bus.imem_req_addr);
            end
         end
         @(posedge clock); #2;
      end
      bus.next_PC_select = 1'b0;
      vectors++;
      if (got != 6 || !req_seen) begin
         miscompares++; $display("FAIL redir_timeout: got %0d decodes req_seen=%b expected 6 and 1", got, req_seen);
      end
   endtask

   task automatic test_wrap();
      logic [AB-1:0] exp_a;
      do_reset(1, 1'b1);
      for (int k = 0; k < 7; k++) begin
         @(negedge clock);
         exp_a = 16'(32'hFFF8 + 4 * k);
         vectors++;
         if (bus_w.imem_req_valid !== 1'b1 || bus_w.imem_req_addr !== exp_a) begin
            miscompares++;
            $display("FAIL wrap_req[%0d]: got v=%b a=%h expected v=1 a=%h", k, bus_w.imem_req_valid, bus_w.imem_req_addr, exp_a);
         end
         if (k >= 2) begin
            exp_a = 16'(32'hFFF8 + 4 * (k - 2));
            vectors++;
            if (bus_w.dec_valid !== 1'b1 || bus_w.PC !== exp_a || bus_w.instruction !== mem_word(exp_a)) begin
               miscompares++;
               $display("FAIL wrap_dec[%0d]: got v=%b pc=%h expected v=1 pc=%h", k, bus_w.dec_valid, bus_w.PC, exp_a);
            end
         end
         @(posedge clock); #2;
      end
   endtask

   task automatic test_random();
      logic [AB-1:0] exp_pc = '0;
      logic [AB-1:0] tgt;
      logic          sel;
      logic          drdy;
      int unsigned   since = 0;
      int unsigned   decodes = 0;
      do_reset(2, 1'b0);
      for (int c = 0; c < 800 && decodes < 60; c++) begin
         drdy = ($urandom_range(0, 3) != 0);
         tgt  = 16'($urandom);
         if (drdy && bus.dec_valid) sel = (since >= 6);
         else                       sel = ($urandom_range(0, 3) == 0);
         bus.imem_req_ready = ($urandom_range(0, 3) != 0);
         bus.dec_ready      = drdy;
         bus.next_PC_select = sel;
         bus.target_PC      = tgt;
         @(negedge clock);
         if (bus.dec_valid && bus.dec_ready) begin
            vectors++;
            if (bus.PC !== exp_pc || bus.instruction !== mem_word(exp_pc)) begin
               miscompares++;
               $display("FAIL rand_dec[%0d]: got pc=%h ins=%h expected pc=%h ins=%h", decodes, bus.PC, bus.instruction, exp_pc, mem_word(exp_pc));
            end
            decodes++;
            if (sel) begin
               exp_pc = tgt & 16'hFFFC;
               since  = 0;
            end else begin
               exp_pc = exp_pc + 16'd4;
               since++;
            end
         end
         @(posedge clock); #2;
      end
      bus.next_PC_select = 1'b0;
      vectors++;
      if (decodes != 60) begin
         miscompares++; $display("FAIL rand_timeout: got %0d decodes expected 60", decodes);
      end
   endtask

   task automatic test_reset_midflight();
      int unsigned fires = 0;
      int unsigned got = 0;
      logic        req_seen = 1'b0;
      do_reset(3, 1'b0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         if (bus.imem_req_valid && bus.imem_req_ready) fires++;
         @(posedge clock); #2;
      end
      vectors++;
      if (fires != 2) begin
         miscompares++; $display("FAIL mid_inflight: got %0d expected 2", fires);
      end
      reset = 1'b1;
      @(posedge clock); #2;
      @(negedge clock);
      vectors++;
      if (bus.dec_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_idle: got dv=%b rv=%b expected 0 0", bus.dec_valid, bus.imem_req_valid);
      end
      @(posedge clock); #2;
      reset         = 1'b0;
      bus.dec_ready = 1'b1;
      for (int c = 0; c < 30 && got < 2; c++) begin
         @(negedge clock);
         if (!req_seen && bus.imem_req_valid && bus.imem_req_ready) begin
            req_seen = 1'b1;
            vectors++;
            if (bus.imem_req_addr !== 16'h0000) begin
               miscompares++; $display("FAIL mid_refetch_addr: got %h expected 0000", bus.imem_req_addr);
            end
         end
         if (bus.dec_valid) begin
            vectors++;
            if (bus.PC !== 16'(4 * got) || bus.instruction !== mem_word(16'(4 * got))) begin
               miscompares++;
               $display("FAIL mid_refetch_dec[%0d]: got pc=%h expected %h", got, bus.PC, 16'(4 * got));
            end
            got++;
         end
         @(posedge clock); #2;
      end
      vectors++;
      if (got != 2 || !req_seen) begin
         miscompares++; $display("FAIL mid_timeout: got %0d decodes req_seen=%b expected 2 and 1", got, req_seen);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_random();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
